// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode constants: major opcodes, format codes and the
// decoded-bundle layout used by the decode stage registers.
package rv_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // XLEN-independent part of a decoded bundle; pc and imm ride alongside.
    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic        illegal;
    } dec_ctl_t;

    localparam int CTL_W = $bits(dec_ctl_t);

    function automatic int bundle_w(input int xlen);
        return 2 * xlen + CTL_W;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: builds the sign-extended immediate for the given format.
module imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Every format's sign bit is instr[31], so widening the 32-bit value is enough.
    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: combinational decode into an output
// register backed by a one-deep skid register, with valid/ready and flush.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_if,
    input  logic [XLEN-1:0] pc_if,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_id,
    output logic [6:0]      opcode,
    output logic [4:0]      rd_id,
    output logic [2:0]      funct3_id,
    output logic [4:0]      rs1_id,
    output logic [4:0]      rs2_id,
    output logic [6:0]      funct7_id,
    output logic [XLEN-1:0] imm_id,
    output logic [2:0]      fmt_id,
    output logic            illegal_id
);

    localparam int BW = bundle_w(XLEN);

    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    dec_ctl_t        dec_ctl;
    logic [BW-1:0]   dec_bundle;

    always_comb begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        case (instruction_if[6:0])
            OPC_OP:        dec_fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:
                           dec_fmt = FMT_I;
            OPC_STORE:     dec_fmt = FMT_S;
            OPC_BRANCH:    dec_fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:
                           dec_fmt = FMT_U;
            OPC_JAL:       dec_fmt = FMT_J;
            OPC_OP_32:     dec_illegal = (XLEN != 64);
            OPC_OP_IMM_32: begin
                if (XLEN == 64) dec_fmt = FMT_I;
                else            dec_illegal = 1'b1;
            end
            default:       dec_illegal = 1'b1;
        endcase
        // Illegal words pass through as R-format so the immediate is forced to zero.
        if (instruction_if[1:0] != 2'b11 || dec_illegal) begin
            dec_illegal = 1'b1;
            dec_fmt     = FMT_R;
        end
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instruction_if),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    assign dec_ctl    = '{instr: instruction_if, fmt: dec_fmt, illegal: dec_illegal};
    assign dec_bundle = {pc_if, dec_imm, dec_ctl};

    logic          or_valid, sk_valid;
    logic [BW-1:0] or_q, sk_q;
    logic          drain, accept, or_free;

    assign drain   = or_valid & out_ready;
    assign or_free = ~or_valid | drain;
    assign in_ready = SKID ? ~sk_valid : (out_ready | ~or_valid);
    assign accept  = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
            or_q     <= '0;
            sk_q     <= '0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (or_free) begin
            // Older skid entry always moves up first to keep order.
            if (sk_valid) begin
                or_q     <= sk_q;
                or_valid <= 1'b1;
                sk_valid <= accept;
                if (accept) sk_q <= dec_bundle;
            end else begin
                or_valid <= accept;
                if (accept) or_q <= dec_bundle;
            end
        end else if (accept) begin
            sk_q     <= dec_bundle;
            sk_valid <= 1'b1;
        end
    end

    dec_ctl_t or_ctl;
    assign or_ctl = or_q[CTL_W-1:0];

    assign out_valid  = or_valid;
    assign pc_id      = or_q[BW-1 -: XLEN];
    assign imm_id     = or_q[CTL_W +: XLEN];
    assign fmt_id     = or_ctl.fmt;
    assign illegal_id = or_ctl.illegal;
    assign opcode     = or_ctl.instr[6:0];
    assign rd_id      = or_ctl.instr[11:7];
    assign funct3_id  = or_ctl.instr[14:12];
    assign rs1_id     = or_ctl.instr[19:15];
    assign rs2_id     = or_ctl.instr[24:20];
    assign funct7_id  = or_ctl.instr[31:25];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: queue-based reference model with a per-cycle
// compare process, plus hand-computed literal checks for the directed vectors.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instruction_if = '0;
    logic [31:0] pc_if = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, illegal_id;
    logic [31:0] pc_id, imm_id;
    logic [6:0]  opcode, funct7_id;
    logic [4:0]  rd_id, rs1_id, rs2_id;
    logic [2:0]  funct3_id, fmt_id;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] pc64, imm64;
    logic [6:0]  opcode64, funct7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  funct3_64, fmt64;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_if(instruction_if), .pc_if(pc_if),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_id(pc_id), .opcode(opcode), .rd_id(rd_id), .funct3_id(funct3_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .funct7_id(funct7_id),
        .imm_id(imm_id), .fmt_id(fmt_id), .illegal_id(illegal_id)
    );

    decode_stage #(.XLEN(64), .SKID(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instruction_if(instruction_if), .pc_if({32'h0, pc_if}),
        .out_valid(out_valid64), .out_ready(out_ready),
        .pc_id(pc64), .opcode(opcode64), .rd_id(rd64), .funct3_id(funct3_64),
        .rs1_id(rs1_64), .rs2_id(rs2_64), .funct7_id(funct7_64),
        .imm_id(imm64), .fmt_id(fmt64), .illegal_id(illegal64)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        int          fmt;
        bit          ill;
    } exp_t;

    // Reference decode for XLEN=32, straight from the format table.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t   e;
        longint imm;
        imm = 0;
        e.fmt = 0;
        e.ill = 1'b0;
        case (i[6:0])
            7'h33: e.fmt = 0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin e.fmt = 1; imm = $signed(i[31:20]); end
            7'h23: begin e.fmt = 2; imm = $signed({i[31:25], i[11:7]}); end
            7'h63: begin e.fmt = 3; imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
            7'h37, 7'h17: begin e.fmt = 4; imm = $signed({i[31:12], 12'h000}); end
            7'h6F: begin e.fmt = 5; imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
            default: e.ill = 1'b1;
        endcase
        e.pc    = pc;
        e.instr = i;
        e.imm   = imm[31:0];
        return e;
    endfunction

    exp_t        q[$];
    logic [31:0] out_log[$];

    // Occupancy model: up to two bundles buffered, oldest presented first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            bit acc;
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(model(instruction_if, pc_if));
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
            check("in_ready", in_ready, (q.size() < 2) ? 1 : 0);
            if (q.size() > 0 && out_valid) begin
                check("pc_id",      pc_id,      q[0].pc);
                check("opcode",     opcode,     q[0].instr[6:0]);
                check("rd_id",      rd_id,      q[0].instr[11:7]);
                check("funct3_id",  funct3_id,  q[0].instr[14:12]);
                check("rs1_id",     rs1_id,     q[0].instr[19:15]);
                check("rs2_id",     rs2_id,     q[0].instr[24:20]);
                check("funct7_id",  funct7_id,  q[0].instr[31:25]);
                check("imm_id",     imm_id,     q[0].imm);
                check("fmt_id",     fmt_id,     q[0].fmt);
                check("illegal_id", illegal_id, q[0].ill);
                if (out_ready) out_log.push_back(pc_id);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        int k;
        in_valid       = 1'b1;
        instruction_if = ins;
        pc_if          = pc;
        k = 0;
        while (!in_ready && k < 50) begin
            step(1);
            k++;
        end
        if (k == 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for pc %0h", pc);
        end
        step(1);
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst in_ready",  in_ready,  1);
        check("rst pc_id",     pc_id,     0);
        check("rst imm_id",    imm_id,    0);
        check("rst opcode",    opcode,    0);
        #11 rst_n = 1'b1;
        mon_en = 1'b1;
        step(1);

        // addi x1,x0,-1
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h100);
        check("t1 rd_id",   rd_id,      1);
        check("t1 fmt_id",  fmt_id,     1);
        check("t1 imm_id",  imm_id,     32'hFFFFFFFF);
        check("t1 illegal", illegal_id, 0);

        send(32'hFE000EE3, 32'h104);
        check("t2 beq fmt", fmt_id, 3);
        check("t2 beq imm", imm_id, 32'hFFFFFFFC);
        send(32'h000010B7, 32'h108);
        check("t2 lui fmt", fmt_id, 4);
        check("t2 lui imm", imm_id, 32'h00001000);
        send(32'h00A12623, 32'h10C);          // sw x10,12(x2)
        check("t2 sw imm", imm_id, 32'h0000000C);
        send(32'hFFDFF0EF, 32'h110);          // jal x1,-4
        check("t2 jal imm", imm_id, 32'hFFFFFFFC);
        check("t2 jal fmt", fmt_id, 5);
        step(2);

        // Backpressure: A in OR, B in SK, C held.
        out_log.delete();
        out_ready = 1'b0;
        send(32'h00100093, 32'h200);
        send(32'h00200113, 32'h204);
        in_valid = 1'b1; instruction_if = 32'h00300193; pc_if = 32'h208;
        step(1);
        check("t3 in_ready held", in_ready, 0);
        check("t3 OR holds A",    pc_id,    32'h200);
        out_ready = 1'b1;
        send(32'h00300193, 32'h208);
        step(3);
        check("t3 out count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("t3 order A", out_log[0], 32'h200);
            check("t3 order B", out_log[1], 32'h204);
            check("t3 order C", out_log[2], 32'h208);
        end

        // Flush with OR and SK full and a new instruction offered.
        out_ready = 1'b0;
        send(32'h00400213, 32'h300);
        send(32'h00500293, 32'h304);
        in_valid = 1'b1; instruction_if = 32'h00600313; pc_if = 32'h308;
        flush = 1'b1;
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        check("t4 out_valid", out_valid, 0);
        check("t4 in_ready",  in_ready,  1);
        out_log.delete();
        out_ready = 1'b1;
        step(4);
        check("t4 nothing out", out_log.size(), 0);

        // Illegal encodings and the XLEN=64-only OP-32.
        send(32'h00000000, 32'h400);
        check("t5 zero illegal", illegal_id, 1);
        check("t5 zero imm",     imm_id,     0);
        send(32'h0000007F, 32'h404);
        check("t5 7f illegal", illegal_id, 1);
        check("t5 7f imm",     imm_id,     0);
        send(32'h0000003B, 32'h408);
        check("t5 addw rv32 illegal", illegal_id,  1);
        check("t5 addw rv64 valid",   out_valid64, 1);
        check("t5 addw rv64 illegal", illegal64,   0);
        check("t5 addw rv64 fmt",     fmt64,       0);
        send(32'hFFF00093, 32'h40C);
        check("t5 rv64 addi imm", imm64, 64'hFFFFFFFFFFFFFFFF);
        step(2);

        // Asynchronous reset while a bundle is held.
        out_ready = 1'b0;
        send(32'h00700393, 32'h500);
        send(32'h00800413, 32'h504);
        check("t6 pre out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async out_valid", out_valid, 0);
        check("t6 async in_ready",  in_ready,  1);
        check("t6 async pc_id",     pc_id,     0);
        step(2);
        #2 rst_n = 1'b1;
        step(1);
        out_log.delete();
        out_ready = 1'b1;
        send(32'h00900493, 32'h600);
        send(32'h00A00513, 32'h604);
        step(3);
        check("t6 out count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t6 first after reset", out_log[0], 32'h600);
            check("t6 second",            out_log[1], 32'h604);
        end
        check("model drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
